// File: rtl/ycbcr_pkg.sv
// Shared constants, types and helpers for the BT.601 full-range YCbCr444 -> RGB888 converter.
// Coefficients are scaled by 2^C_FRAC; all datapath arithmetic is signed.
package ycbcr_pkg;

    localparam int C_R_CR       = 359;
    localparam int C_G_CB       = 88;
    localparam int C_G_CR       = 183;
    localparam int C_B_CB       = 454;
    localparam int C_CHROMA_OFS = 128;
    localparam int C_RND        = 128;
    localparam int C_FRAC       = 8;
    localparam int LP_LAT       = 4;

    localparam int WD_ACC       = 20;
    localparam int WD_DLT       = 9;

    localparam int ERR_R        = 0;
    localparam int ERR_G        = 1;
    localparam int ERR_B        = 2;
    localparam int ERR_SYNC     = 3;
    localparam int ERR_USED     = 4;

    typedef logic signed [WD_ACC-1:0] acc_t;
    typedef logic signed [WD_DLT-1:0] dlt_t;

    typedef struct packed {
        acc_t r_cr;
        acc_t g_cb;
        acc_t g_cr;
        acc_t b_cb;
    } prod_t;

    function automatic dlt_t chroma_delta(input logic [7:0] c);
        return dlt_t'({1'b0, c}) - dlt_t'(C_CHROMA_OFS);
    endfunction

    function automatic acc_t mul_coef(input dlt_t d, input int coef);
        return acc_t'(d) * acc_t'(coef);
    endfunction

endpackage

// File: rtl/ycbcr444_to_rgb888_sat_u8.sv
// Final stage helper: drops the fractional bits of a rounded fixed-point sum and
// saturates it into an unsigned 8-bit component, flagging whenever it had to clamp.
module sat_u8
    import ycbcr_pkg::*;
(
    input  logic signed [WD_ACC-1:0] sum_i,
    output logic        [7:0]        pix_o,
    output logic                     clamp_o
);

    logic signed [WD_ACC-1:0] shifted;

    always_comb begin
        shifted = sum_i >>> C_FRAC;
        pix_o   = shifted[7:0];
        clamp_o = 1'b0;
        if (shifted < 0) begin
            pix_o   = 8'h00;
            clamp_o = 1'b1;
        end else if (shifted > acc_t'(255)) begin
            pix_o   = 8'hFF;
            clamp_o = 1'b1;
        end
    end

endmodule

// File: rtl/ycbcr444_to_rgb888.sv
// Four-stage YCbCr444 -> RGB888 converter (offset, multiply, sum, shift/clamp) with
// matched sync delay lines and sticky, set-dominant clamp/sync-protocol error flags.
module ycbcr444_to_rgb888
    import ycbcr_pkg::*;
#(
    parameter int MD_SIM_ABLE = 0,
    parameter int WD_IMG_DATA = 8,
    parameter int WD_ERR_INFO = 4
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_resetn,
    input  logic                   s_img_ycbcr444_c_fsync,
    input  logic                   s_img_ycbcr444_c_vsync,
    input  logic                   s_img_ycbcr444_c_hsync,
    input  logic [WD_IMG_DATA-1:0] s_img_ycbcr444_y_mdat0,
    input  logic [WD_IMG_DATA-1:0] s_img_ycbcr444_b_mdat1,
    input  logic [WD_IMG_DATA-1:0] s_img_ycbcr444_r_mdat2,
    input  logic                   i_err_clr,
    output logic                   m_img_rgb888_c_fsync,
    output logic                   m_img_rgb888_c_vsync,
    output logic                   m_img_rgb888_c_hsync,
    output logic [WD_IMG_DATA-1:0] m_img_rgb888_r_mdat0,
    output logic [WD_IMG_DATA-1:0] m_img_rgb888_g_mdat1,
    output logic [WD_IMG_DATA-1:0] m_img_rgb888_b_mdat2,
    output logic [WD_ERR_INFO-1:0] m_err_ycbcr444_info1
);

    if (WD_IMG_DATA != 8 || WD_ERR_INFO < ERR_USED || MD_SIM_ABLE < 0) begin : g_param_check
        $error("ycbcr444_to_rgb888: unsupported parameter set");
    end

    acc_t                y1_q, y1_d;
    dlt_t                dcb_q, dcb_d;
    dlt_t                dcr_q, dcr_d;
    acc_t                y2_q;
    prod_t               prod_q, prod_d;
    acc_t                sum_r_q, sum_r_d;
    acc_t                sum_g_q, sum_g_d;
    acc_t                sum_b_q, sum_b_d;
    logic [7:0]          r_q, g_q, b_q;
    logic [LP_LAT-1:0]   fs_q, vs_q, hs_q;
    logic [ERR_USED-1:0] err_q, err_d;

    logic [7:0]          sat_r, sat_g, sat_b;
    logic                clamp_r, clamp_g, clamp_b;

    always_comb begin
        y1_d        = acc_t'(s_img_ycbcr444_y_mdat0) <<< C_FRAC;
        dcb_d       = chroma_delta(s_img_ycbcr444_b_mdat1);
        dcr_d       = chroma_delta(s_img_ycbcr444_r_mdat2);

        prod_d.r_cr = mul_coef(dcr_q, C_R_CR);
        prod_d.g_cb = mul_coef(dcb_q, C_G_CB);
        prod_d.g_cr = mul_coef(dcr_q, C_G_CR);
        prod_d.b_cb = mul_coef(dcb_q, C_B_CB);

        sum_r_d     = y2_q + prod_q.r_cr + acc_t'(C_RND);
        sum_g_d     = y2_q - prod_q.g_cb - prod_q.g_cr + acc_t'(C_RND);
        sum_b_d     = y2_q + prod_q.b_cb + acc_t'(C_RND);
    end

    sat_u8 u_sat_r (.sum_i(sum_r_q), .pix_o(sat_r), .clamp_o(clamp_r));
    sat_u8 u_sat_g (.sum_i(sum_g_q), .pix_o(sat_g), .clamp_o(clamp_g));
    sat_u8 u_sat_b (.sum_i(sum_b_q), .pix_o(sat_b), .clamp_o(clamp_b));

    // hs_q[LP_LAT-2] is the hsync travelling with the pixel now entering the clamp stage.
    always_comb begin
        err_d = i_err_clr ? '0 : err_q;
        if (hs_q[LP_LAT-2]) begin
            err_d[ERR_R] = err_d[ERR_R] | clamp_r;
            err_d[ERR_G] = err_d[ERR_G] | clamp_g;
            err_d[ERR_B] = err_d[ERR_B] | clamp_b;
        end
        err_d[ERR_SYNC] = err_d[ERR_SYNC] | (s_img_ycbcr444_c_hsync & ~s_img_ycbcr444_c_vsync);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            y1_q    <= '0;
            dcb_q   <= '0;
            dcr_q   <= '0;
            y2_q    <= '0;
            prod_q  <= '0;
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            fs_q    <= '0;
            vs_q    <= '0;
            hs_q    <= '0;
            err_q   <= '0;
        end else begin
            y1_q    <= y1_d;
            dcb_q   <= dcb_d;
            dcr_q   <= dcr_d;
            y2_q    <= y1_q;
            prod_q  <= prod_d;
            sum_r_q <= sum_r_d;
            sum_g_q <= sum_g_d;
            sum_b_q <= sum_b_d;
            r_q     <= sat_r;
            g_q     <= sat_g;
            b_q     <= sat_b;
            fs_q    <= {fs_q[LP_LAT-2:0], s_img_ycbcr444_c_fsync};
            vs_q    <= {vs_q[LP_LAT-2:0], s_img_ycbcr444_c_vsync};
            hs_q    <= {hs_q[LP_LAT-2:0], s_img_ycbcr444_c_hsync};
            err_q   <= err_d;
        end
    end

    assign m_img_rgb888_c_fsync = fs_q[LP_LAT-1];
    assign m_img_rgb888_c_vsync = vs_q[LP_LAT-1];
    assign m_img_rgb888_c_hsync = hs_q[LP_LAT-1];
    assign m_img_rgb888_r_mdat0 = r_q;
    assign m_img_rgb888_g_mdat1 = g_q;
    assign m_img_rgb888_b_mdat2 = b_q;
    assign m_err_ycbcr444_info1 = WD_ERR_INFO'(err_q);

endmodule
